// File: rtl/program_loader_pkg.sv
// program_loader_pkg: state encodings and framing constants shared by the program loader.
package program_loader_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_HI = 3'd1;
    localparam logic [2:0] LEN_LO = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;

    localparam int HEADER_BYTES   = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_word_assembler.sv
// word_assembler: packs MSB-first bytes into 32-bit words.
// o_word_ready pulses alongside the final byte of each word.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [23:0] r_shift;
    logic [1:0]  r_index;

    assign o_word       = {r_shift, i_byte};
    assign o_word_ready = i_valid && (r_index == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_index <= '0;
        end else if (i_clear) begin
            r_index <= '0;
        end else if (i_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_index <= r_index + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: boot loader that writes a length-prefixed byte image into program memory, then releases the core.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 64,
    parameter int ADDR_WIDTH   = $clog2(MEMORY_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [31:0]           mem_data_o,
    output logic                  core_reset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [15:0]           word_count_o
);

    localparam logic [15:0] DEPTH_W = 16'(MEMORY_DEPTH);

    logic [2:0]            r_state;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_count;
    logic [15:0]           r_widx;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_data;
    logic                  r_done;
    logic                  r_core_reset;

    logic        w_start;
    logic        w_accept;
    logic        w_data_acc;
    logic        w_last;
    logic        w_word_ready;
    logic        w_sum_ok;
    logic [15:0] w_len;
    logic [31:0] w_word;

    assign byte_ready_o  = r_state inside {LEN_HI, LEN_LO, DATA, CHECK};
    assign busy_o        = byte_ready_o;
    assign error_o       = r_state == ERROR;
    assign done_o        = r_done;
    assign core_reset_o  = r_core_reset;
    assign mem_write_o   = r_mem_write;
    assign mem_address_o = r_mem_addr;
    assign mem_data_o    = r_mem_data;
    assign word_count_o  = r_count;

    assign w_start    = load_start_i && (r_state inside {IDLE, DONE, ERROR});
    assign w_accept   = byte_valid_i && byte_ready_o;
    assign w_data_acc = w_accept && (r_state == DATA);
    assign w_len      = {r_len_hi, byte_data_i};
    assign w_last     = r_widx == r_count - 16'd1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] END_STATE = CHECK;
    logic [7:0] r_xor;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_xor <= '0;
        else if (w_start)
            r_xor <= '0;
        else if (w_data_acc)
            r_xor <= r_xor ^ byte_data_i;
    end
    assign w_sum_ok = r_xor == byte_data_i;
`else
    localparam logic [2:0] END_STATE = DONE;
    assign w_sum_ok = 1'b1;
`endif

    word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start),
        .i_valid      (w_data_acc),
        .i_byte       (byte_data_i),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    // The core is released one cycle after DONE is entered, i.e. after the final write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_len_hi     <= '0;
            r_count      <= '0;
            r_widx       <= '0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_done       <= 1'b0;
            r_core_reset <= 1'b1;
        end else begin
            r_mem_write <= 1'b0;
            if (w_start) begin
                r_state      <= LEN_HI;
                r_widx       <= '0;
                r_done       <= 1'b0;
                r_core_reset <= 1'b1;
            end else if (r_state == DONE) begin
                r_done       <= 1'b1;
                r_core_reset <= 1'b0;
            end else if (w_accept) begin
                case (r_state)
                    LEN_HI: begin
                        r_len_hi <= byte_data_i;
                        r_state  <= LEN_LO;
                    end
                    LEN_LO: begin
                        r_count <= w_len;
                        r_state <= (w_len == 16'd0) ? END_STATE : (w_len > DEPTH_W) ? ERROR : DATA;
                    end
                    DATA: if (w_word_ready) begin
                        r_mem_write <= 1'b1;
                        r_mem_data  <= w_word;
                        r_mem_addr  <= r_widx[ADDR_WIDTH-1:0];
                        r_widx      <= r_widx + 16'd1;
                        if (w_last)
                            r_state <= END_STATE;
                    end
                    CHECK: r_state <= w_sum_ok ? DONE : ERROR;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed stimulus with a transaction-level image model and a per-cycle output checker.
module tb_program_loader;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start_i = 1'b0;
    logic          byte_valid_i = 1'b0;
    logic [7:0]    byte_data_i = 8'h00;
    logic          byte_ready_o;
    logic          mem_write_o;
    logic [AW-1:0] mem_address_o;
    logic [31:0]   mem_data_o;
    logic          core_reset_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [15:0]   word_count_o;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          rel_at = -10;
    int          n_writes = 0;
    logic [31:0] mem_img [DEPTH];
    wr_t         exp_q[$];
    wr_t         w_pop;

    program_loader #(.MEMORY_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start_i  (load_start_i),
        .byte_valid_i  (byte_valid_i),
        .byte_data_i   (byte_data_i),
        .byte_ready_o  (byte_ready_o),
        .mem_write_o   (mem_write_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .core_reset_o  (core_reset_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .word_count_o  (word_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Image model: every complete word present in the stream, if the header length is legal.
    function automatic void plan(bq_t s);
        int cnt;
        exp_q.delete();
        if (s.size() < 2) return;
        cnt = {s[0], s[1]};
        if (cnt == 0 || cnt > DEPTH) return;
        for (int i = 0; i < cnt && 2 + 4 * i + 3 < s.size(); i++)
            exp_q.push_back('{i, {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]}});
    endfunction

    function automatic logic [7:0] xsum(bq_t s);
        logic [7:0] x = 8'h00;
        for (int i = 2; i < s.size(); i++) x ^= s[i];
        return x;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_equals_busy", byte_ready_o, busy_o);
            chk("core_reset_vs_done", core_reset_o, !done_o);
            if (mem_write_o) begin
                n_writes++;
                mem_img[mem_address_o] = mem_data_o;
                chk("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    w_pop = exp_q.pop_front();
                    chk("write_addr", mem_address_o, w_pop.addr);
                    chk("write_data", mem_data_o, w_pop.data);
                end
            end
            if (cyc == rel_at - 1) chk("release_not_early", core_reset_o, 1);
            if (cyc == rel_at) begin
                chk("release_latency_core_reset", core_reset_o, 0);
                chk("release_latency_done", done_o, 1);
            end
        end
    end

    task automatic pulse_start();
        load_start_i = 1'b1;
        @(posedge clk); #1;
        load_start_i = 1'b0;
    endtask

    task automatic send(logic [7:0] b);
        bit acc = 1'b0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = byte_ready_o;
            @(posedge clk); #1;
        end
        if (!acc) chk("byte_accept_timeout", acc, 1);
        byte_valid_i = 1'b0;
    endtask

    task automatic run(bq_t s, bit gap, int inj, bit add_sum, bit good);
        bq_t full = s;
        if (add_sum && SUM_EN) full.push_back(xsum(s));
        n_writes = 0;
        plan(s);
        pulse_start();
        foreach (full[i]) begin
            send(full[i]);
            if (good && i == full.size() - 1) rel_at = cyc + 1;
            if (gap) begin
                load_start_i = (i == inj);
                @(posedge clk); #1;
                load_start_i = 1'b0;
            end
        end
    endtask

    task automatic check_end(string tag, bit d, bit e, bit cr, int wc, int nw);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done"}, done_o, d);
        chk({tag, "_error"}, error_o, e);
        chk({tag, "_core_reset"}, core_reset_o, cr);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_word_count"}, word_count_o, wc);
        chk({tag, "_writes"}, n_writes, nw);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        bq_t s_two, s_bad, s_part, s_one, s_zero;
        s_two  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        s_bad  = '{8'h00, 8'h41};
        s_part = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01};
        s_one  = '{8'h00, 8'h01, 8'hde, 8'had, 8'hbe, 8'hef};
        s_zero = '{8'h00, 8'h00};
        foreach (mem_img[i]) mem_img[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_core_reset", core_reset_o, 1);
        chk("reset_byte_ready", byte_ready_o, 0);
        chk("reset_mem_write", mem_write_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_error", error_o, 0);
        chk("reset_word_count", word_count_o, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run(s_two, 0, -1, 1, 1);
        check_end("two_word", 1, 0, 0, 2, 2);
        chk("two_word_img0", mem_img[0], 32'h20080005);
        chk("two_word_img1", mem_img[1], 32'h01095020);

        run(s_bad, 0, -1, 0, 0);
        check_end("oversize", 0, 1, 1, 16'h41, 0);
        chk("oversize_ready", byte_ready_o, 0);

        mem_img[0] = 32'h0;
        mem_img[1] = 32'h0;
        run(s_two, 1, 6, 1, 1);
        check_end("gapped", 1, 0, 0, 2, 2);
        chk("gapped_img0", mem_img[0], 32'h20080005);
        chk("gapped_img1", mem_img[1], 32'h01095020);

        run(s_part, 0, -1, 0, 0);
        reset = 1'b1;
        #1;
        chk("midload_busy", busy_o, 0);
        chk("midload_core_reset", core_reset_o, 1);
        chk("midload_ready", byte_ready_o, 0);
        chk("midload_word_count", word_count_o, 0);
        chk("midload_partial_writes", n_writes, 1);
        chk("midload_pending", exp_q.size(), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run(s_one, 0, -1, 1, 1);
        check_end("restart", 1, 0, 0, 1, 1);
        chk("restart_img0", mem_img[0], 32'hdeadbeef);

        run(s_zero, 0, -1, 1, 1);
        check_end("zero_len", 1, 0, 0, 0, 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        begin
            bq_t s_ok, s_ng;
            s_ok = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
            s_ng = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
            chk("xsum_model", xsum(s_ok) ^ 8'h08, 8'h08);
            run(s_ok, 0, -1, 0, 1);
            check_end("sum_match", 1, 0, 0, 1, 1);
            chk("sum_match_img0", mem_img[0], 32'h12345678);
            run(s_ng, 0, -1, 0, 0);
            check_end("sum_mismatch", 0, 1, 1, 1, 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
